// File: rtl/dmem_write_buffer_if.sv
// Cache-side and memory-side signal bundle of the data-memory write buffer.
// The slave modport is the buffer's view; master is the cache/memory side.
interface dmem_write_buffer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic              c_read;
   logic              c_write;
   logic [DATA_W-1:0] c_rdata;
   logic              c_ready;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_read;
   logic              m_write;
   logic [DATA_W-1:0] m_rdata;
   logic              m_ack;

   modport master (
      output c_addr, c_wdata, c_read, c_write, m_rdata, m_ack,
      input  c_rdata, c_ready, m_addr, m_wdata, m_read, m_write
   );

   modport slave (
      input  c_addr, c_wdata, c_read, c_write, m_rdata, m_ack,
      output c_rdata, c_ready, m_addr, m_wdata, m_read, m_write
   );
endinterface

// File: rtl/dmem_write_buffer.sv
// Write-back buffer between the data cache and data memory: FIFO of dirty
// words with coalescing, read forwarding, and read-miss priority over draining.
module dmem_write_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   dmem_write_buffer_if.slave         bus,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t            state, state_nxt;
   logic [DEPTH-1:0]  ent_vld;
   logic [ADDR_W-3:0] ent_addr [DEPTH];
   logic [DATA_W-1:0] ent_data [DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;

   logic [ADDR_W-3:0] key;
   logic [PTR_W-1:0]  scan_idx, fwd_idx, co_idx;
   logic              fwd_hit, co_hit;
   logic              do_write, do_read, coalesce, push, pop;
   logic              start_read, start_drain;
   logic [DATA_W-1:0] head_wdata;

   assign key   = bus.c_addr[ADDR_W-1:2];
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

   // Scan oldest to newest so the last match found is the newest entry.
   // The head is not a coalesce target while its data sits on m_wdata.
   always_comb begin
      scan_idx = '0;
      fwd_hit  = 1'b0;
      fwd_idx  = '0;
      co_hit   = 1'b0;
      co_idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = rd_ptr + PTR_W'(k);
         if (ent_vld[scan_idx] && (ent_addr[scan_idx] == key)) begin
            fwd_hit = 1'b1;
            fwd_idx = scan_idx;
            if (!((state == DRAIN) && (scan_idx == rd_ptr))) begin
               co_hit = 1'b1;
               co_idx = scan_idx;
            end
         end
      end
   end

   assign do_write = bus.c_write && !reset;
   assign do_read  = bus.c_read && !bus.c_write && !reset;
   assign coalesce = do_write && co_hit;
   assign push     = do_write && !co_hit && !full;
   assign pop      = (state == DRAIN) && bus.m_ack;

   assign bus.c_ready = coalesce || push ||
                        (do_read && (fwd_hit || ((state == READ) && bus.m_ack)));
   assign bus.c_rdata = reset   ? '0 :
                        fwd_hit ? ent_data[fwd_idx] : bus.m_rdata;

   // A write coalescing into the head as its drain launches must reach memory.
   assign head_wdata = (coalesce && (co_idx == rd_ptr)) ? bus.c_wdata
                                                        : ent_data[rd_ptr];

   always_comb begin
      state_nxt   = state;
      start_read  = 1'b0;
      start_drain = 1'b0;
      case (state)
         IDLE: begin
            if (do_read && !fwd_hit) begin
               state_nxt  = READ;
               start_read = 1'b1;
            end else if (!empty) begin
               state_nxt   = DRAIN;
               start_drain = 1'b1;
            end
         end
         READ:    if (bus.m_ack) state_nxt = IDLE;
         DRAIN:   if (bus.m_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Memory-side request registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.m_read  <= 1'b0;
         bus.m_write <= 1'b0;
         bus.m_addr  <= '0;
         bus.m_wdata <= '0;
      end else begin
         if (start_read) begin
            bus.m_addr <= bus.c_addr;
            bus.m_read <= 1'b1;
         end else if (start_drain) begin
            bus.m_addr  <= {ent_addr[rd_ptr], 2'b00};
            bus.m_wdata <= head_wdata;
            bus.m_write <= 1'b1;
         end
         if ((state == READ) && bus.m_ack) bus.m_read <= 1'b0;
         if (pop) bus.m_write <= 1'b0;
      end
   end

   // FIFO control: valid bits, pointers, occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ent_vld <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
      end else begin
         if (push) begin
            ent_vld[wr_ptr] <= 1'b1;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            ent_vld[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Entry payload storage
   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr[wr_ptr] <= key;
         ent_data[wr_ptr] <= bus.c_wdata;
      end
      if (coalesce) ent_data[co_idx] <= bus.c_wdata;
   end
endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer with a memory model that checks every
// memory transaction against a queue of expected transactions.
module tb_dmem_write_buffer;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int CNT_W  = $clog2(DEPTH+1);

   typedef struct {
      logic              rd;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } txn_t;

   logic             clk;
   logic             reset;
   logic             empty;
   logic             full;
   logic [CNT_W-1:0] count;

   dmem_write_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   dmem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .empty (empty),
      .full  (full),
      .count (count)
   );

   txn_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   busy  = 0;
   int   mem_lat = 2;
   bit   mem_hold = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory responder: acks a request after mem_lat visible cycles unless held.
   task automatic mem_model();
      txn_t e;
      if (bus.m_write || bus.m_read) begin
         busy++;
         if (!mem_hold && busy >= mem_lat) begin
            bus.m_ack = 1'b1;
            check("mem_expected_txn", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("mem_kind_rd", 64'(bus.m_read), 64'(e.rd));
               check("mem_addr", 64'(bus.m_addr), 64'(e.addr));
               if (e.rd) bus.m_rdata = e.data;
               else      check("mem_wdata", 64'(bus.m_wdata), 64'(e.data));
            end
         end else begin
            bus.m_ack = 1'b0;
         end
      end else begin
         busy      = 0;
         bus.m_ack = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      mem_model();
   endtask

   task automatic exp_txn(input logic rd, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      txn_t e;
      e.rd = rd; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   // Present a write, expect same-cycle acceptance, then release it.
   task automatic cache_write(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.c_addr = a; bus.c_wdata = d; bus.c_write = 1'b1;
      #1;
      check({tag, "_ready"}, 64'(bus.c_ready), 64'd1);
      tick();
      bus.c_write = 1'b0;
   endtask

   task automatic drain_all(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !empty) && n < 300) begin
         tick();
         n++;
      end
      check({tag, "_drained"}, 64'((exp_q.size() == 0) && empty), 64'd1);
   endtask

   initial begin
      logic got;
      reset = 1'b1;
      bus.c_addr = '0; bus.c_wdata = '0; bus.c_read = 1'b0; bus.c_write = 1'b0;
      bus.m_rdata = '0; bus.m_ack = 1'b0;

      // Reset state, with a write request held to show c_ready is suppressed
      bus.c_write = 1'b1; bus.c_addr = 32'h10;
      tick(); tick();
      #1;
      check("rst_c_ready", 64'(bus.c_ready), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_m_write", 64'(bus.m_write), 64'd0);
      check("rst_m_read", 64'(bus.m_read), 64'd0);
      check("rst_m_addr", 64'(bus.m_addr), 64'd0);
      check("rst_c_rdata", 64'(bus.c_rdata), 64'd0);
      tick();
      bus.c_write = 1'b0;
      reset = 1'b0;
      tick();

      // Push/drain in FIFO order
      exp_txn(1'b0, 32'h100, 32'hA1);
      exp_txn(1'b0, 32'h104, 32'hA2);
      exp_txn(1'b0, 32'h108, 32'hA3);
      cache_write("pd_w0", 32'h100, 32'hA1);
      check("pd_count1", 64'(count), 64'd1);
      cache_write("pd_w1", 32'h104, 32'hA2);
      check("pd_count2", 64'(count), 64'd2);
      cache_write("pd_w2", 32'h108, 32'hA3);
      check("pd_count3", 64'(count), 64'd3);
      drain_all("pd");
      check("pd_empty", 64'(empty), 64'd1);
      check("pd_m_write_low", 64'(bus.m_write), 64'd0);

      // Full stall with the head held in DRAIN
      mem_hold = 1'b1;
      exp_txn(1'b0, 32'h180, 32'hB0);
      exp_txn(1'b0, 32'h184, 32'hB1);
      exp_txn(1'b0, 32'h188, 32'hB2);
      exp_txn(1'b0, 32'h18C, 32'hB3);
      exp_txn(1'b0, 32'h200, 32'hB4);
      cache_write("fs_w0", 32'h180, 32'hB0);
      cache_write("fs_w1", 32'h184, 32'hB1);
      cache_write("fs_w2", 32'h188, 32'hB2);
      cache_write("fs_w3", 32'h18C, 32'hB3);
      check("fs_count4", 64'(count), 64'd4);
      bus.c_addr = 32'h200; bus.c_wdata = 32'hB4; bus.c_write = 1'b1;
      #1;
      check("fs_stall_ready", 64'(bus.c_ready), 64'd0);
      check("fs_full", 64'(full), 64'd1);
      tick(); #1;
      check("fs_stall_ready2", 64'(bus.c_ready), 64'd0);
      mem_hold = 1'b0;
      tick(); #1;
      check("fs_ack_m_ack", 64'(bus.m_ack), 64'd1);
      check("fs_ready_at_ack", 64'(bus.c_ready), 64'd0);
      tick(); #1;
      check("fs_ready_after_pop", 64'(bus.c_ready), 64'd1);
      tick();
      bus.c_write = 1'b0;
      check("fs_count_back4", 64'(count), 64'd4);
      drain_all("fs");

      // Coalesce into the idle head, then forward from it
      exp_txn(1'b0, 32'h40, 32'h22);
      cache_write("co_w0", 32'h40, 32'h11);
      cache_write("co_w1", 32'h40, 32'h22);
      check("co_count", 64'(count), 64'd1);
      bus.c_addr = 32'h40; bus.c_read = 1'b1;
      #1;
      check("co_fwd_ready", 64'(bus.c_ready), 64'd1);
      check("co_fwd_data", 64'(bus.c_rdata), 64'h22);
      check("co_no_m_read", 64'(bus.m_read), 64'd0);
      tick();
      bus.c_read = 1'b0;
      check("co_no_m_read2", 64'(bus.m_read), 64'd0);
      drain_all("co");

      // Head protection: matching write during DRAIN appends a new entry
      mem_hold = 1'b1;
      exp_txn(1'b0, 32'h40, 32'h44);
      exp_txn(1'b0, 32'h40, 32'h33);
      cache_write("hp_w0", 32'h40, 32'h44);
      tick();
      check("hp_draining", 64'(bus.m_write), 64'd1);
      check("hp_m_wdata", 64'(bus.m_wdata), 64'h44);
      cache_write("hp_w1", 32'h40, 32'h33);
      check("hp_count2", 64'(count), 64'd2);
      bus.c_addr = 32'h40; bus.c_read = 1'b1;
      #1;
      check("hp_fwd_ready", 64'(bus.c_ready), 64'd1);
      check("hp_fwd_newest", 64'(bus.c_rdata), 64'h33);
      check("hp_m_wdata_kept", 64'(bus.m_wdata), 64'h44);
      tick();
      bus.c_read = 1'b0;
      mem_hold = 1'b0;
      drain_all("hp");

      // Read miss waits for the in-flight drain, then beats the next drain
      mem_hold = 1'b1;
      exp_txn(1'b0, 32'h500, 32'h1);
      exp_txn(1'b1, 32'h300, 32'hDEAD);
      exp_txn(1'b0, 32'h504, 32'h2);
      cache_write("rp_w0", 32'h500, 32'h1);
      cache_write("rp_w1", 32'h504, 32'h2);
      bus.c_addr = 32'h300; bus.c_read = 1'b1;
      #1;
      check("rp_miss_wait", 64'(bus.c_ready), 64'd0);
      tick(); #1;
      check("rp_miss_wait2", 64'(bus.c_ready), 64'd0);
      mem_hold = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         tick(); #1;
         got = bus.c_ready;
      end
      check("rp_miss_ready", 64'(got), 64'd1);
      check("rp_miss_rdata", 64'(bus.c_rdata), 64'hDEAD);
      check("rp_second_pending", 64'(count), 64'd1);
      tick();
      bus.c_read = 1'b0;
      drain_all("rp");

      // Reset in the middle of a drain
      mem_hold = 1'b1;
      exp_txn(1'b0, 32'h600, 32'h7);
      cache_write("rm_w0", 32'h600, 32'h7);
      tick();
      check("rm_draining", 64'(bus.m_write), 64'd1);
      reset = 1'b1;
      bus.c_addr = 32'h604; bus.c_wdata = 32'h8; bus.c_write = 1'b1;
      #1;
      check("rm_m_write", 64'(bus.m_write), 64'd0);
      check("rm_count", 64'(count), 64'd0);
      check("rm_empty", 64'(empty), 64'd1);
      check("rm_c_ready", 64'(bus.c_ready), 64'd0);
      exp_q.delete();
      tick(); #1;
      check("rm_c_ready_held", 64'(bus.c_ready), 64'd0);
      bus.c_write = 1'b0;
      reset = 1'b0;
      mem_hold = 1'b0;
      tick(); tick(); tick();
      check("rm_idle_after", 64'(bus.m_write | bus.m_read), 64'd0);
      check("rm_empty_after", 64'(empty), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
